rom_loader: RTL and testbench
=============================

ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 23, memory byte-address width.
REQ-002 SHALL have parameter SEG_BITS, default 14, log2 of segment size in bytes (16 KB).
REQ-003 SHALL have parameter NSEG, default 3, number of mapped download segments (1..16).
REQ-004 SHALL have parameter SEG_MAP, default {9'h107,9'h100,9'h000}, packed target pages; entry i occupies bits [i*PW +: PW], where PW = ADDR_W-SEG_BITS.
REQ-005 SHALL have parameter RAM_PAGES, default 256, count of pages below which unmapped addresses are RAM.
REQ-006 SHALL have port clk_sys, input, 1, the single system clock; all logic on its rising edge.
REQ-007 SHALL have port reset_n, input, 1, asynchronous, active-low reset.
REQ-008 SHALL have port clkref, input, 1, one-cycle memory-slot strobe.
REQ-009 SHALL have port download, input, 1, ROM download in progress.
REQ-010 SHALL have port ioctl_wr, input, 1, byte-valid strobe from host.
REQ-011 SHALL have port ioctl_addr, input, 25, download byte offset.
REQ-012 SHALL have port ioctl_dout, input, 8, download byte.
REQ-013 SHALL have port ioctl_wait, output, 1, host stall while a byte is pending.
REQ-014 SHALL have port mem_we, output, 1, memory write request.
REQ-015 SHALL have port mem_addr, output, ADDR_W, memory write address.
REQ-016 SHALL have port mem_din, output, 8, memory write data.
REQ-017 SHALL have port query_addr, input, ADDR_W, CPU read address for mask lookup.
REQ-018 SHALL have port rom_mask, output, 8, OR-mask for read data.
REQ-019 SHALL have port loaded, output, NSEG, per-segment loaded flags.
REQ-020 SHALL have port done, output, 1, one-cycle pulse at download end.
REQ-021 SHALL have port checksum, output, 8, present only with ROM_LOADER_CHECKSUM_EN.

Function
REQ-022 SHALL implement a state machine with states IDLE, PEND and WRITE.
REQ-023 In IDLE, when download=1 and ioctl_wr=1, it SHALL compute s = ioctl_addr[24:SEG_BITS].
REQ-024 If s<NSEG, the accepted byte SHALL, on the next edge, latch mem_addr={SEG_MAP[s],ioctl_addr[SEG_BITS-1:0]} and mem_din=ioctl_dout, set ioctl_wait=1, and move to PEND.
REQ-025 If s>=NSEG, the byte SHALL be dropped: no write, ioctl_wait stays 0, state stays IDLE.
REQ-026 An ioctl_wr arriving in PEND or WRITE SHALL be ignored; the host contract forbids it.
REQ-027 In PEND, the first clkref SHALL set mem_we=1 and move to WRITE.
REQ-028 In WRITE, the next clkref SHALL clear mem_we and ioctl_wait, set loaded[s], and return to IDLE; mem_we is thus held exactly one clkref period.
REQ-029 A rising edge of download SHALL clear loaded (and checksum).
REQ-030 A falling edge of download SHALL pulse done for one cycle.
REQ-031 If download falls during PEND or WRITE, the pending write SHALL still complete; done SHALL pulse on the falling-edge cycle regardless.
REQ-032 rom_mask SHALL be combinational on page p=query_addr[ADDR_W-1:SEG_BITS].
REQ-033 If p matches SEG_MAP[i], rom_mask SHALL be 8'h00 when loaded[i]=1 and 8'hFF otherwise; on duplicate map entries the lowest i wins.
REQ-034 If p matches no SEG_MAP entry, rom_mask SHALL be 8'h00 for p<RAM_PAGES and 8'hFF otherwise.

Reset
REQ-035 While reset_n=0, state SHALL be IDLE and ioctl_wait, mem_we, done, loaded, mem_addr, mem_din and checksum SHALL all be 0.
REQ-036 Reset mid-transaction SHALL abandon the transaction without a write and without setting the loaded flag.
REQ-037 The download edge detector SHALL reset to 0, so a download already high at reset release counts as a rising edge.

Configuration
REQ-038 With macro ROM_LOADER_CHECKSUM_EN defined, checksum SHALL be the mod-256 sum of accepted bytes, updated on acceptance, not on dropped bytes.
REQ-039 Without ROM_LOADER_CHECKSUM_EN, the checksum port and its logic SHALL be absent.

Verification
REQ-040 ioctl_addr=0x4005, data 0xA5, clkref every 16 cycles -> mem_addr=0x400005, mem_din=0xA5, mem_we high for exactly 16 cycles, ioctl_wait drops with it, loaded=3'b010.
REQ-041 ioctl_addr=0xC000 (s=3, NSEG=3) -> no mem_we, ioctl_wait stays 0, loaded unchanged.
REQ-042 query_addr=0x41C000 before and after loading segment 2 -> rom_mask 0xFF then 0x00; query_addr=0x010000 -> 0x00; query_addr=0x500000 -> 0xFF.
REQ-043 download falls while in PEND -> write still issued, done pulses once, ioctl_wait returns 0.
REQ-044 reset_n low while in WRITE -> mem_we and ioctl_wait are 0 immediately (asynchronously), loaded=0.
REQ-045 With ROM_LOADER_CHECKSUM_EN, bytes 0xFF,0x02 to segment 0 plus 0x10 to segment 5 -> checksum=0x01.

Source files
------------

// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : rom_loader
// Description : Routes host ROM-download bytes into mapped memory segments,
//               one write per clkref slot, and derives a read OR-mask per page.
//               Optional checksum output: define ROM_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_loader #(
  parameter int ADDR_W    = 23,
  parameter int SEG_BITS  = 14,
  parameter int NSEG      = 3,
  parameter logic [NSEG*(ADDR_W-SEG_BITS)-1:0] SEG_MAP = {9'h107, 9'h100, 9'h000},
  parameter int RAM_PAGES = 256
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              clkref,
  input  logic              download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [ADDR_W-1:0] query_addr,
  output logic [7:0]        rom_mask,
  output logic [NSEG-1:0]   loaded,
  output logic              done
`ifdef ROM_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]        checksum
`endif
);

  localparam int c_pw = ADDR_W - SEG_BITS;
  localparam int c_sw = 25 - SEG_BITS;
  localparam logic [c_pw:0] c_ram_pages = (c_pw + 1)'(RAM_PAGES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PEND  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_dl_prev;
  logic [NSEG-1:0] r_seg_oh;

  logic [c_sw-1:0] w_seg;
  logic            w_hit;
  logic [c_pw-1:0] w_page;
  logic [NSEG-1:0] w_seg_oh;
  logic            w_rise;
  logic            w_accept;
  logic [NSEG-1:0] w_loaded_base;
  logic [c_pw-1:0] w_qpage;
  logic            w_unused;

  assign w_seg   = ioctl_addr[24:SEG_BITS];
  assign w_qpage = query_addr[ADDR_W-1:SEG_BITS];
  assign w_unused = ^query_addr[SEG_BITS-1:0];

  always_comb begin
    w_hit    = 1'b0;
    w_page   = '0;
    w_seg_oh = '0;
    for (int i = 0; i < NSEG; i++) begin
      if (w_seg == c_sw'(i)) begin
        w_hit       = 1'b1;
        w_page      = SEG_MAP[i*c_pw +: c_pw];
        w_seg_oh[i] = 1'b1;
      end
    end
  end

  // Descending scan so the lowest matching map entry has the final say.
  always_comb begin
    rom_mask = ({1'b0, w_qpage} < c_ram_pages) ? 8'h00 : 8'hFF;
    for (int i = NSEG - 1; i >= 0; i--) begin
      if (w_qpage == SEG_MAP[i*c_pw +: c_pw]) begin
        rom_mask = loaded[i] ? 8'h00 : 8'hFF;
      end
    end
  end

  assign w_rise        = download & ~r_dl_prev;
  assign w_accept      = (r_state == S_IDLE) & download & ioctl_wr & w_hit;
  assign w_loaded_base = w_rise ? '0 : loaded;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_dl_prev  <= 1'b0;
      r_seg_oh   <= '0;
      ioctl_wait <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      loaded     <= '0;
      done       <= 1'b0;
    end else begin
      r_dl_prev <= download;
      done      <= r_dl_prev & ~download;
      loaded    <= w_loaded_base;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            mem_addr   <= {w_page, ioctl_addr[SEG_BITS-1:0]};
            mem_din    <= ioctl_dout;
            r_seg_oh   <= w_seg_oh;
            ioctl_wait <= 1'b1;
            r_state    <= S_PEND;
          end
        end
        S_PEND: begin
          if (clkref) begin
            mem_we  <= 1'b1;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (clkref) begin
            mem_we     <= 1'b0;
            ioctl_wait <= 1'b0;
            loaded     <= w_loaded_base | r_seg_oh;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  // A byte accepted on the same edge as a new download starts a fresh sum.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= '0;
    end else if (w_accept) begin
      checksum <= (w_rise ? 8'h00 : checksum) + ioctl_dout;
    end else if (w_rise) begin
      checksum <= '0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_loader
// Description : Self-checking bench for rom_loader: transaction-level model
//               compared every cycle, plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        clkref = 1'b0;
  logic        download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [22:0] query_addr = '0;
  logic        ioctl_wait, mem_we, done;
  logic [22:0] mem_addr;
  logic [7:0]  mem_din, rom_mask;
  logic [2:0]  loaded;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  rom_loader dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .clkref(clkref), .download(download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .query_addr(query_addr), .rom_mask(rom_mask), .loaded(loaded), .done(done)
`ifdef ROM_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One-cycle memory slot every 16 clocks.
  bit ref_en = 1'b0;
  int ref_cnt = 0;
  always @(posedge clk_sys) begin
    #2;
    if (ref_en) begin
      ref_cnt++;
      clkref = (ref_cnt % 16 == 0);
    end else begin
      clkref = 1'b0;
    end
  end

  // Behavioural model: a pending byte waits for two memory slots; the first
  // opens the write, the second closes it and marks the segment loaded.
  localparam logic [8:0] PG [3] = '{9'h000, 9'h100, 9'h107};
  logic        m_wait = 0, m_we = 0, m_done = 0, m_dl = 0, m_busy = 0;
  logic [22:0] m_addr = '0;
  logic [7:0]  m_din = '0, m_sum = '0;
  logic [2:0]  m_loaded = '0;
  int          m_seg = 0, m_refs = 0, m_s = 0;

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      m_wait = 0; m_we = 0; m_done = 0; m_dl = 0; m_busy = 0;
      m_addr = '0; m_din = '0; m_sum = '0; m_loaded = '0;
    end else begin
      m_s    = int'(ioctl_addr >> 14);
      m_done = m_dl && !download;
      if (download && !m_dl) begin
        m_loaded = '0;
        m_sum    = '0;
      end
      if (m_busy) begin
        if (clkref) begin
          m_refs++;
          if (m_refs == 1) m_we = 1;
          else begin
            m_we = 0; m_wait = 0; m_busy = 0;
            m_loaded[m_seg] = 1'b1;
          end
        end
      end else if (download && ioctl_wr && m_s < 3) begin
        m_addr = {PG[m_s], ioctl_addr[13:0]};
        m_din  = ioctl_dout;
        m_wait = 1; m_busy = 1; m_refs = 0; m_seg = m_s;
        m_sum  = m_sum + ioctl_dout;
      end
      m_dl = download;
    end
  end

  function automatic logic [7:0] exp_mask(input logic [22:0] q, input logic [2:0] ld);
    logic [8:0] p;
    p = q[22:14];
    for (int i = 0; i < 3; i++) if (p == PG[i]) return ld[i] ? 8'h00 : 8'hFF;
    return (p < 9'd256) ? 8'h00 : 8'hFF;
  endfunction

  bit cmp_on = 1'b0;
  always @(negedge clk_sys) begin
    if (cmp_on) begin
      check("ioctl_wait", 32'(ioctl_wait), 32'(m_wait));
      check("mem_we",     32'(mem_we),     32'(m_we));
      check("mem_addr",   32'(mem_addr),   32'(m_addr));
      check("mem_din",    32'(mem_din),    32'(m_din));
      check("loaded",     32'(loaded),     32'(m_loaded));
      check("done",       32'(done),       32'(m_done));
      check("rom_mask",   32'(rom_mask),   32'(exp_mask(query_addr, m_loaded)));
`ifdef ROM_LOADER_CHECKSUM_EN
      check("checksum",   32'(checksum),   32'(m_sum));
`endif
    end
  end

  int we_cnt = 0, wait_cnt = 0, done_cnt = 0;
  always @(negedge clk_sys) begin
    if (mem_we) we_cnt++;
    if (ioctl_wait) wait_cnt++;
    if (done) done_cnt++;
  end

  task automatic clear_counts();
    we_cnt = 0; wait_cnt = 0; done_cnt = 0;
  endtask

  task automatic send(input logic [24:0] a, input logic [7:0] d);
    @(posedge clk_sys); #2;
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    @(posedge clk_sys); #2;
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk_sys);
      if (!ioctl_wait) ok = 1'b1;
    end
    check("idle_timeout", 32'(ok), 1);
  endtask

  task automatic set_query(input logic [22:0] q);
    @(posedge clk_sys); #2;
    query_addr = q;
    @(negedge clk_sys);
  endtask

  initial begin
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_wait",   32'(ioctl_wait), 0);
    check("rst_we",     32'(mem_we),     0);
    check("rst_loaded", 32'(loaded),     0);
    check("rst_addr",   32'(mem_addr),   0);
    check("rst_done",   32'(done),       0);
    cmp_on = 1'b1;
    @(posedge clk_sys); #2 reset_n = 1'b1;

    set_query(23'h41C000); check("mask_seg2_empty", 32'(rom_mask), 'hFF);
    set_query(23'h010000); check("mask_ram",        32'(rom_mask), 'h00);
    set_query(23'h500000); check("mask_unmapped",   32'(rom_mask), 'hFF);
    set_query(23'h400000);

    // Segment 1 write
    @(posedge clk_sys); #2;
    download = 1'b1; ref_en = 1'b1;
    repeat (2) @(posedge clk_sys); #2;
    clear_counts();
    send(25'h004005, 8'hA5);
    wait_idle();
    check("we_len_seg1",  32'(we_cnt),   16);
    check("addr_seg1",    32'(mem_addr), 'h400005);
    check("din_seg1",     32'(mem_din),  'hA5);
    check("loaded_seg1",  32'(loaded),   'b010);
    check("mask_seg1",    32'(rom_mask), 'h00);

    // Out-of-range segment is dropped
    clear_counts();
    send(25'h00C000, 8'h5A);
    repeat (20) @(negedge clk_sys);
    check("drop_we",     32'(we_cnt),   0);
    check("drop_wait",   32'(wait_cnt), 0);
    check("drop_loaded", 32'(loaded),   'b010);

    // Segment 2 write, then mask clears
    clear_counts();
    send(25'h008123, 8'h3C);
    wait_idle();
    check("addr_seg2", 32'(mem_addr), 'h41C123);
    check("loaded_seg2", 32'(loaded), 'b110);
    set_query(23'h41C000); check("mask_seg2_loaded", 32'(rom_mask), 'h00);

    // download falls while the byte is pending
    clear_counts();
    send(25'h000010, 8'h77);
    download = 1'b0;
    @(negedge clk_sys);
    check("pend_wait", 32'(ioctl_wait), 1);
    wait_idle();
    repeat (3) @(negedge clk_sys);
    check("fall_done_cnt", 32'(done_cnt),   1);
    check("fall_we_len",   32'(we_cnt),     16);
    check("fall_addr",     32'(mem_addr),   'h000010);
    check("fall_loaded",   32'(loaded),     'b111);
    check("fall_wait",     32'(ioctl_wait), 0);

    // Asynchronous reset during WRITE
    @(posedge clk_sys); #2 download = 1'b1;
    repeat (2) @(posedge clk_sys);
    send(25'h004000, 8'h11);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk_sys);
        if (mem_we) seen = 1'b1;
      end
      check("reach_write", 32'(seen), 1);
    end
    #3 reset_n = 1'b0;
    #1;
    check("arst_we",     32'(mem_we),     0);
    check("arst_wait",   32'(ioctl_wait), 0);
    check("arst_loaded", 32'(loaded),     0);
    clear_counts();
    repeat (3) @(posedge clk_sys);
    #2 reset_n = 1'b1;
    repeat (40) @(negedge clk_sys);
    check("arst_no_write",  32'(we_cnt), 0);
    check("arst_loaded_after", 32'(loaded), 0);

`ifdef ROM_LOADER_CHECKSUM_EN
    @(posedge clk_sys); #2 download = 1'b0;
    repeat (2) @(posedge clk_sys); #2 download = 1'b1;
    repeat (2) @(posedge clk_sys);
    send(25'h000000, 8'hFF); wait_idle();
    send(25'h000001, 8'h02); wait_idle();
    send(25'h014000, 8'h10);
    repeat (5) @(negedge clk_sys);
    check("checksum_lit", 32'(checksum), 'h01);
`endif

    repeat (3) @(negedge clk_sys);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
